// File: rtl/onehot_arbiter.sv
// onehot_arbiter: registered N-way arbiter with LSB/MSB/round-robin priority, grant locking and bounded hold
module onehot_arbiter #(
  parameter int N_REQ    = 4,
  parameter int W_IDX    = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       mode,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [W_IDX-1:0] gnt_idx,
  output logic             gnt_new
);
  localparam logic [7:0] HOLD_MAX = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
  localparam logic [W_IDX-1:0] LAST_RST = W_IDX'(N_REQ - 1);

  logic [N_REQ-1:0] gnt_q, gnt_d, wait_v;
  logic [W_IDX-1:0] idx_q, idx_d, last_q, last_d;
  logic [7:0]       hold_q, hold_d;
  logic             new_q, new_d;

  function automatic logic [N_REQ-1:0] pick(input logic [N_REQ-1:0] v, input logic [1:0] m,
                                            input logic [W_IDX-1:0] last);
    logic [N_REQ-1:0] r;
    int p;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      p = (m == 2'd1) ? N_REQ - 1 - i : (m == 2'd2) ? (int'(last) + 1 + i) % N_REQ : i;
      if (v[p]) begin
        r = '0;
        r[p] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [W_IDX-1:0] idx_of(input logic [N_REQ-1:0] g);
    logic [W_IDX-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) if (g[i]) r = W_IDX'(i);
    return r;
  endfunction

  assign wait_v = req & ~gnt_q;

  always_comb begin
    gnt_d  = gnt_q;
    hold_d = hold_q;
    last_d = last_q;
    new_d  = 1'b0;
    if (gnt_q == '0) begin
      gnt_d  = pick(req, mode, last_q);
      new_d  = |req;
      hold_d = '0;
    end else if ((gnt_q & req) == '0) begin
      gnt_d  = pick(req, mode, last_q);
      new_d  = |req;
      hold_d = '0;
      last_d = idx_q;
    end else if (MAX_HOLD != 0 && hold_q == HOLD_MAX && wait_v != '0) begin
      // owner still requesting but has used its hold budget while others wait
      gnt_d  = pick(wait_v, mode, last_q);
      new_d  = 1'b1;
      hold_d = '0;
      last_d = idx_q;
    end else begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 8'd1;
    end
    idx_d = (gnt_d != '0) ? idx_of(gnt_d) : idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q  <= '0;
      idx_q  <= '0;
      new_q  <= 1'b0;
      hold_q <= '0;
      last_q <= LAST_RST;
    end else begin
      gnt_q  <= gnt_d;
      idx_q  <= idx_d;
      new_q  <= new_d;
      hold_q <= hold_d;
      last_q <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_new   = new_q;
endmodule

// File: tb/tb_onehot_arbiter.sv
// tb_onehot_arbiter: directed-vector bench for onehot_arbiter (MAX_HOLD=4 and a MAX_HOLD=0 twin)
module tb_onehot_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [1:0] mode;
  logic [3:0] gnt, gnt0;
  logic       gnt_valid, gnt_valid0, gnt_new, gnt_new0;
  logic [1:0] gnt_idx, gnt_idx0;
  int vec = 0;
  int miss = 0;

  always #5 clk = ~clk;

  onehot_arbiter #(.N_REQ(4), .W_IDX(2), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_new(gnt_new)
  );

  onehot_arbiter #(.N_REQ(4), .W_IDX(2), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .gnt(gnt0), .gnt_valid(gnt_valid0), .gnt_idx(gnt_idx0), .gnt_new(gnt_new0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; mode = 2'd0;
    tick(); tick();
    vec++; if (gnt !== 4'b0000) begin miss++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    vec++; if (gnt_valid !== 1'b0) begin miss++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
    vec++; if (gnt_idx !== 2'd0) begin miss++; $display("FAIL reset_idx: got %0d want 0", gnt_idx); end
    vec++; if (gnt_new !== 1'b0) begin miss++; $display("FAIL reset_new: got %b want 0", gnt_new); end
    rst = 1'b0;
    tick();
    vec++; if (gnt !== 4'b0001) begin miss++; $display("FAIL post_reset_gnt: got %b want 0001", gnt); end
    vec++; if (gnt_new !== 1'b1 || gnt_valid !== 1'b1) begin miss++; $display("FAIL post_reset_new: got new=%b valid=%b want 1 1", gnt_new, gnt_valid); end
    tick();
    vec++; if (gnt_new !== 1'b0 || gnt !== 4'b0001) begin miss++; $display("FAIL new_pulse: got new=%b gnt=%b want 0 0001", gnt_new, gnt); end
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 2'd1; req = 4'b0110;
    tick();
    vec++; if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin miss++; $display("FAIL msb_pick: got gnt=%b idx=%0d want 0100 2", gnt, gnt_idx); end
    req = 4'b0010;
    tick();
    vec++; if (gnt !== 4'b0010 || gnt_idx !== 2'd1 || gnt_new !== 1'b1 || gnt_valid !== 1'b1) begin miss++; $display("FAIL release_handoff: got gnt=%b idx=%0d new=%b valid=%b want 0010 1 1 1", gnt, gnt_idx, gnt_new, gnt_valid); end
    req = 4'b0000;
    tick();
    vec++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd1 || gnt_new !== 1'b0) begin miss++; $display("FAIL idle_idx_hold: got gnt=%b valid=%b idx=%0d new=%b want 0000 0 1 0", gnt, gnt_valid, gnt_idx, gnt_new); end
    mode = 2'd3; req = 4'b1010;
    tick();
    vec++; if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin miss++; $display("FAIL mode3_lsb: got gnt=%b idx=%0d want 0010 1", gnt, gnt_idx); end
  endtask

  task automatic test_round_robin();
    logic [3:0] reqs [5] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] exps [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    mode = 2'd2;
    for (int i = 0; i < 5; i++) begin
      req = reqs[i];
      tick();
      vec++; if (gnt !== exps[i] || gnt_new !== 1'b1) begin miss++; $display("FAIL rr_step%0d: got gnt=%b new=%b want %b 1", i, gnt, gnt_new, exps[i]); end
    end
  endtask

  task automatic test_preempt();
    do_reset();
    mode = 2'd0; req = 4'b0001;
    for (int i = 0; i < 10; i++) tick();
    vec++; if (gnt !== 4'b0001 || gnt0 !== 4'b0001) begin miss++; $display("FAIL lone_hold: got gnt=%b gnt0=%b want 0001 0001", gnt, gnt0); end
    req = 4'b0011;
    tick();
    vec++; if (gnt !== 4'b0010 || gnt_new !== 1'b1) begin miss++; $display("FAIL preempt: got gnt=%b new=%b want 0010 1", gnt, gnt_new); end
    vec++; if (gnt0 !== 4'b0001 || gnt_new0 !== 1'b0) begin miss++; $display("FAIL no_preempt_hold0: got gnt=%b new=%b want 0001 0", gnt0, gnt_new0); end
    for (int i = 0; i < 8; i++) tick();
    vec++; if (gnt0 !== 4'b0001) begin miss++; $display("FAIL hold0_long: got %b want 0001", gnt0); end
  endtask

  task automatic test_hold_limit();
    logic [3:0] exps [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    for (int m = 0; m < 2; m++) begin
      do_reset();
      mode = (m == 0) ? 2'd0 : 2'd2;
      req = 4'b0011;
      for (int i = 0; i < 9; i++) begin
        tick();
        vec++; if (gnt !== exps[i] || gnt_new !== (i % 4 == 0)) begin miss++; $display("FAIL hold_m%0d_c%0d: got gnt=%b new=%b want %b %b", m, i, gnt, gnt_new, exps[i], i % 4 == 0); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 2'd2; req = 4'b0100;
    tick();
    req = 4'b0110;
    tick(); tick();
    vec++; if (gnt !== 4'b0100) begin miss++; $display("FAIL mid_setup: got %b want 0100", gnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0 || gnt_new !== 1'b0) begin miss++; $display("FAIL mid_reset: got gnt=%b valid=%b idx=%0d new=%b want 0000 0 0 0", gnt, gnt_valid, gnt_idx, gnt_new); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vec++; if (gnt !== 4'b0010) begin miss++; $display("FAIL mid_regrant_c%0d: got %b want 0010", i, gnt); end
    end
    tick();
    vec++; if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin miss++; $display("FAIL mid_handoff: got gnt=%b idx=%0d want 0100 2", gnt, gnt_idx); end
  endtask

  initial begin
    rst = 1'b1; req = '0; mode = '0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_preempt();
    test_hold_limit();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
